fe_tx_framer: RTL and testbench

//  Transmit-side framer for the FE serial link; counterpart to the BE receive buffer.

---
 rtl/fe_link_pkg.sv | 32 +++
 rtl/fe_tx_framer_if.sv | 27 ++
 rtl/fe_tx_framer.sv | 164 ++++++++++++++++
 tb/tb_fe_tx_framer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_link_pkg.sv
// ---------------------------------------------------------------------------
// fe_link_pkg
// Constants and types shared by the FE transmit framer and the BE receive
// buffer control: frame delimiter words, the idle/comma word with its K flags,
// the payload length, and the framer state enum.
// ---------------------------------------------------------------------------
package fe_link_pkg;

  localparam logic [15:0] START_WORD     = 16'hDEAD;
  localparam logic [15:0] END_WORD       = 16'hBEEF;
  // Low byte is K28.5 (0xBC), so the receiver can align on it.
  localparam logic [15:0] IDLE_WORD      = 16'h50BC;
  localparam logic [1:0]  IDLE_K         = 2'b01;
  localparam logic [1:0]  DATA_K         = 2'b00;
  localparam int          FE_PAYLOAD_LEN = 125;
  localparam int          FE_MIN_GAP     = 4;

  // Each state names the word that will be emitted next.
  typedef enum logic [2:0] {
    GAP,
    SOF,
    TS,
    PAYLOAD,
    EOF
  } fe_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fe_tx_framer_if.sv
// ---------------------------------------------------------------------------
// fe_tx_framer_if
// Upstream payload stream between the FE sample FIFO and the TX framer.
//   s_data   16  payload word
//   s_valid   1  s_data valid
//   s_ready   1  consumer accepts s_data this cycle
// master: the word source (FIFO side); slave: the framer.
// ---------------------------------------------------------------------------
interface fe_tx_framer_if;

  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/fe_tx_framer.sv
// ---------------------------------------------------------------------------
// fe_tx_framer
// Transmit-side framer for the FE serial link. Packs upstream payload words
// into frames  START_WORD, timestamp, PAYLOAD_LEN payload words, END_WORD
// and fills every other cycle with K-char idle words. Drives the 16-bit
// transceiver TX parallel port, one word per cycle.
// Ports:
//   tx_std_clkout     in   1   TX parallel clock (only clock)
//   rst               in   1   asynchronous reset, active-high
//   tx_ready          in   1   transceiver TX ready / link up
//   enable            in   1   frame generation enable
//   src               slave    upstream payload stream (s_data/s_valid/s_ready)
//   tx_parallel_data  out  16  word to transceiver
//   tx_datak          out  2   K flags for tx_parallel_data
//   frame_cnt         out  16  frames completed (END_WORD sent), wraps
//   underrun_cnt      out  16  payload slots filled with idle, saturates
//   busy              out  1   high for every word from SOF through EOF
// ---------------------------------------------------------------------------
module fe_tx_framer
  import fe_link_pkg::*;
#(
  parameter int          PAYLOAD_LEN = FE_PAYLOAD_LEN,
  parameter logic [15:0] START_WORD  = fe_link_pkg::START_WORD,
  parameter logic [15:0] END_WORD    = fe_link_pkg::END_WORD,
  parameter logic [15:0] IDLE_WORD   = fe_link_pkg::IDLE_WORD,
  parameter logic [1:0]  IDLE_K      = fe_link_pkg::IDLE_K,
  parameter int          MIN_GAP     = FE_MIN_GAP
) (
  input  logic                 tx_std_clkout,
  input  logic                 rst,
  input  logic                 tx_ready,
  input  logic                 enable,
  fe_tx_framer_if.slave        src,
  output logic [15:0]          tx_parallel_data,
  output logic [1:0]           tx_datak,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          underrun_cnt,
  output logic                 busy
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

  fe_state_e        state_q, state_d;
  logic [15:0]      ts_q;
  logic [15:0]      ts_latch_q;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      data_d;
  logic [1:0]       datak_d;
  logic             latch_ts;
  logic             frame_done;
  logic             underrun_hit;
  logic             accept;

  // The source is only ever offered a slot while a payload word is due and
  // the link can take it, so nothing is consumed around the frame delimiters.
  assign src.s_ready = (state_q == PAYLOAD) && tx_ready;
  assign accept      = src.s_valid && src.s_ready;

  // Next-state and next-word logic. Every cycle emits exactly one word; when
  // the word a state wants to send cannot go out (link not ready, or no
  // payload available) an idle is sent instead and the state holds. The gap
  // counter counts idles emitted in GAP including the current one, saturating
  // once the minimum gap has been satisfied.
  always_comb begin
    state_d      = state_q;
    pay_cnt_d    = pay_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    data_d       = IDLE_WORD;
    datak_d      = IDLE_K;
    latch_ts     = 1'b0;
    frame_done   = 1'b0;
    underrun_hit = 1'b0;
    unique case (state_q)
      GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
        if ((gap_cnt_q == GAP_LAST) && enable && tx_ready) begin
          state_d = SOF;
        end
      end
      SOF: begin
        if (tx_ready) begin
          data_d   = START_WORD;
          datak_d  = DATA_K;
          latch_ts = 1'b1;
          state_d  = TS;
        end
      end
      TS: begin
        if (tx_ready) begin
          data_d    = ts_latch_q;
          datak_d   = DATA_K;
          pay_cnt_d = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          data_d    = src.s_data;
          datak_d   = DATA_K;
          pay_cnt_d = pay_cnt_q + 1'b1;
          if (pay_cnt_q == LAST_IDX) begin
            state_d = EOF;
          end
        end else if (!src.s_valid) begin
          underrun_hit = 1'b1;
        end
      end
      EOF: begin
        if (tx_ready) begin
          data_d     = END_WORD;
          datak_d    = DATA_K;
          frame_done = 1'b1;
          gap_cnt_d  = '0;
          state_d    = GAP;
        end
      end
      default: begin
        state_d = GAP;
      end
    endcase
  end

  // State, counters and the registered TX port. busy reflects the state the
  // word was generated in, so it lines up with the word on tx_parallel_data.
  // The timestamp captured in SOF is the free-running count of that cycle.
  always_ff @(posedge tx_std_clkout or posedge rst) begin
    if (rst) begin
      state_q          <= GAP;
      gap_cnt_q        <= '0;
      pay_cnt_q        <= '0;
      ts_q             <= '0;
      ts_latch_q       <= '0;
      tx_parallel_data <= IDLE_WORD;
      tx_datak         <= IDLE_K;
      busy             <= 1'b0;
      frame_cnt        <= '0;
      underrun_cnt     <= '0;
    end else begin
      state_q          <= state_d;
      gap_cnt_q        <= gap_cnt_d;
      pay_cnt_q        <= pay_cnt_d;
      ts_q             <= ts_q + 16'd1;
      tx_parallel_data <= data_d;
      tx_datak         <= datak_d;
      busy             <= (state_q != GAP);
      if (latch_ts) begin
        ts_latch_q <= ts_q;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (underrun_hit) begin
        underrun_cnt <= sat_inc16(underrun_cnt);
      end
    end
  end

endmodule

// File: tb/tb_fe_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_fe_tx_framer
// Directed bench for fe_tx_framer. A reference model describes the output as
// a position within a frame (negative = between frames) and predicts each
// word, K flag, busy, counters and s_ready; a compare process checks them on
// every falling edge. Literal checks pin frame layout, timestamps and gaps.
// ---------------------------------------------------------------------------
module tb_fe_tx_framer;
  import fe_link_pkg::*;

  localparam int LEN     = FE_PAYLOAD_LEN;
  localparam int MIN_GAP = FE_MIN_GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] tx_parallel_data;
  logic [1:0]  tx_datak;
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;
  logic        busy;

  fe_tx_framer_if bus ();

  fe_tx_framer dut (
    .tx_std_clkout   (clk),
    .rst             (rst),
    .tx_ready        (tx_ready),
    .enable          (enable),
    .src             (bus),
    .tx_parallel_data(tx_parallel_data),
    .tx_datak        (tx_datak),
    .frame_cnt       (frame_cnt),
    .underrun_cnt    (underrun_cnt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: frame position 0=START, 1=timestamp, 2..LEN+1 payload,
  // LEN+2=END, -1 between frames.
  int          m_pos = -1;
  int          m_gaps = 0;
  int          m_ts = 0;
  int          m_ts_latch = 0;
  int          m_frames = 0;
  int          m_under = 0;
  int          cyc = 0;
  logic [15:0] e_data = IDLE_WORD;
  logic [1:0]  e_k = IDLE_K;
  logic        e_busy = 1'b0;

  // Stimulus controls.
  bit special_mode = 0;
  int stall_idx = -1;
  int stall_left = 0;
  bit drop_armed = 0;
  int drop_left = 0;
  int en_off_idx = -1;

  // Data-word capture (datak=00) with the cycle each appeared.
  logic [15:0] k0_words[$];
  int          k0_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pay_word(input int idx);
    logic [31:0] v;
    if (special_mode && idx == 10) return 16'hBEEF;
    if (special_mode && idx == 11) return 16'hDEAD;
    v = 32'h1000 + idx;
    return v[15:0];
  endfunction

  // Reference model, advanced once per rising edge from the inputs that were
  // presented during the preceding cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1; m_gaps = 0; m_ts = 0; m_ts_latch = 0;
      m_frames = 0; m_under = 0; cyc = 0;
      e_data = IDLE_WORD; e_k = IDLE_K; e_busy = 1'b0;
    end else begin
      cyc++;
      e_busy = (m_pos >= 0);
      e_data = IDLE_WORD;
      e_k    = IDLE_K;
      if (m_pos < 0) begin
        m_gaps++;
        if (m_gaps >= MIN_GAP && enable && tx_ready) m_pos = 0;
      end else if (m_pos >= 2 && m_pos <= LEN + 1) begin
        if (bus.s_valid && tx_ready) begin
          e_data = bus.s_data;
          e_k    = 2'b00;
          m_pos++;
        end else if (!bus.s_valid && m_under < 65535) begin
          m_under++;
        end
      end else if (tx_ready) begin
        e_k = 2'b00;
        if (m_pos == 0) begin
          e_data = START_WORD;
          m_ts_latch = m_ts;
        end else if (m_pos == 1) begin
          e_data = m_ts_latch[15:0];
        end else begin
          e_data = END_WORD;
          m_frames = (m_frames + 1) % 65536;
        end
        if (m_pos == LEN + 2) begin
          m_pos = -1;
          m_gaps = 0;
        end else begin
          m_pos++;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end
  end

  // Compare DUT against the model on every falling edge and log data words.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_data", tx_parallel_data, IDLE_WORD);
      checkOutput("rst_datak", tx_datak, IDLE_K);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_cnt", frame_cnt, 0);
      checkOutput("rst_underrun", underrun_cnt, 0);
      checkOutput("rst_s_ready", bus.s_ready, 0);
    end else begin
      checkOutput("data", tx_parallel_data, e_data);
      checkOutput("datak", tx_datak, e_k);
      checkOutput("busy", busy, e_busy);
      checkOutput("frame_cnt", frame_cnt, m_frames);
      checkOutput("underrun_cnt", underrun_cnt, m_under);
      checkOutput("s_ready", bus.s_ready,
                  (m_pos >= 2 && m_pos <= LEN + 1 && tx_ready) ? 1 : 0);
      if (tx_datak == 2'b00) begin
        k0_words.push_back(tx_parallel_data);
        k0_cyc.push_back(cyc);
      end
    end
  end

  // Drive inputs #1 after each rising edge for n cycles.
  task automatic applyStimulus(input int n);
    int pidx;
    repeat (n) begin
      @(posedge clk);
      #1;
      pidx = m_pos - 2;
      if (m_pos >= 2 && m_pos <= LEN + 1 && stall_left > 0 && pidx == stall_idx) begin
        bus.s_valid = 1'b0;
        stall_left--;
      end else begin
        bus.s_valid = 1'b1;
      end
      bus.s_data = pay_word((pidx >= 0) ? pidx : 0);
      if (drop_armed && m_pos == 1) begin
        drop_armed = 0;
        drop_left = 5;
      end
      if (drop_left > 0) begin
        tx_ready = 1'b0;
        drop_left--;
      end else begin
        tx_ready = 1'b1;
      end
      if (en_off_idx >= 0 && pidx == en_off_idx) enable = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b1; tx_ready = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = pay_word(0);
    special_mode = 0; stall_idx = -1; stall_left = 0;
    drop_armed = 0; drop_left = 0; en_off_idx = -1;
    k0_words.delete(); k0_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_frame_at(input string name, input int base, input int span);
    checkOutput({name, "_sof"}, k0_words[base], START_WORD);
    checkOutput({name, "_eof"}, k0_words[base + LEN + 2], END_WORD);
    checkOutput({name, "_span"}, k0_cyc[base + LEN + 2] - k0_cyc[base], span);
  endtask

  initial begin
    int bad;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0000;

    // 1: back-to-back frame after the initial gap.
    $display("[TB] test 1: basic frame");
    do_reset();
    applyStimulus(135);
    checkOutput("t1_words", k0_words.size(), LEN + 3);
    if (k0_words.size() >= LEN + 3) begin
      checkOutput("t1_sof_cycle", k0_cyc[0], 5);
      checkOutput("t1_ts", k0_words[1], 4);
      checkOutput("t1_first_payload", k0_words[2], 16'h1000);
      check_frame_at("t1", 0, LEN + 2);
    end
    checkOutput("t1_frame_cnt", frame_cnt, 1);

    // 2: three-cycle underrun at payload index 50.
    $display("[TB] test 2: underrun");
    do_reset();
    stall_idx = 50; stall_left = 3;
    applyStimulus(140);
    checkOutput("t2_underrun", underrun_cnt, 3);
    checkOutput("t2_words", k0_words.size(), LEN + 3);
    if (k0_words.size() >= LEN + 3) begin
      bad = 0;
      for (int i = 0; i < LEN; i++) if (k0_words[2 + i] !== pay_word(i)) bad++;
      checkOutput("t2_payload_order", bad, 0);
      check_frame_at("t2", 0, LEN + 5);
    end

    // 3: delimiter values inside the payload pass through untouched.
    $display("[TB] test 3: verbatim delimiters");
    do_reset();
    special_mode = 1;
    applyStimulus(135);
    checkOutput("t3_words", k0_words.size(), LEN + 3);
    if (k0_words.size() >= LEN + 3) begin
      checkOutput("t3_idx10", k0_words[12], 16'hBEEF);
      checkOutput("t3_idx11", k0_words[13], 16'hDEAD);
      check_frame_at("t3", 0, LEN + 2);
    end

    // 4: three continuous frames.
    $display("[TB] test 4: continuous frames");
    do_reset();
    applyStimulus(400);
    checkOutput("t4_frame_cnt", frame_cnt, 3);
    checkOutput("t4_words", k0_words.size(), 3 * (LEN + 3));
    if (k0_words.size() >= 3 * (LEN + 3)) begin
      for (int f = 1; f < 3; f++) begin
        checkOutput("t4_gap", k0_cyc[f * 128] - k0_cyc[f * 128 - 1], MIN_GAP + 1);
        checkOutput("t4_ts_delta", k0_words[f * 128 + 1] - k0_words[(f - 1) * 128 + 1], 132);
        check_frame_at("t4", f * 128, LEN + 2);
      end
    end

    // 5: link drop during TS, enable removed mid-payload.
    $display("[TB] test 5: tx_ready drop and enable off");
    do_reset();
    drop_armed = 1;
    en_off_idx = 70;
    applyStimulus(300);
    checkOutput("t5_frame_cnt", frame_cnt, 1);
    checkOutput("t5_words", k0_words.size(), LEN + 3);
    if (k0_words.size() >= 2) begin
      checkOutput("t5_ts_cycle", k0_cyc[1], 11);
      checkOutput("t5_ts_value", k0_words[1], 4);
    end
    checkOutput("t5_busy_idle", busy, 0);

    // 6: reset pulse in the middle of the payload.
    $display("[TB] test 6: reset mid-frame");
    do_reset();
    for (int i = 0; i < 300 && m_pos != 62; i++) applyStimulus(1);
    checkOutput("t6_reach_idx60", m_pos, 62);
    rst = 1'b1;
    #1;
    checkOutput("t6_idle", tx_parallel_data, IDLE_WORD);
    checkOutput("t6_idle_k", tx_datak, IDLE_K);
    checkOutput("t6_frame_cnt", frame_cnt, 0);
    checkOutput("t6_underrun", underrun_cnt, 0);
    k0_words.delete(); k0_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(10);
    checkOutput("t6_words", k0_words.size() >= 2 ? 1 : 0, 1);
    if (k0_words.size() >= 2) begin
      checkOutput("t6_sof_cycle", k0_cyc[0], 5);
      checkOutput("t6_sof", k0_words[0], START_WORD);
      checkOutput("t6_ts", k0_words[1], 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
